vram_display_fetch: RTL

Master-clock-domain read engine that sits directly upstream of the video row buffer. On a start pulse it reads one display row of ROW_WORDS consecutive 24-bit tuples from VRAM, beginning at a latched 20-bit word address. It presents the returned words as a column-indexed write stream of column, data and valid. It arbitrates with the VRAM port through a request/grant handshake and bounds the number of in-flight reads.

---
 rtl/vram_pkg.sv | 12 +
 rtl/vram_display_fetch.sv | 135 +++++++++++++
 2 files changed

// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared widths and fetch FSM encoding for the VRAM display path
package vram_pkg;
  localparam int VRAM_ADDR_W = 20;
  localparam int TUPLE_W     = 24;
  localparam int COLUMN_W    = 9;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/vram_display_fetch.sv
// rtl/vram_display_fetch.sv - reads one display row of tuples from VRAM and
// streams them out as column-indexed words for the row buffer.
module vram_display_fetch
  import vram_pkg::*;
#(
  parameter int ROW_WORDS       = 512,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   i_master_clk,
  input  logic                   i_reset,
  input  logic [VRAM_ADDR_W-1:0] i_display_address,
  input  logic                   i_display_start,
  output logic [COLUMN_W-1:0]    o_display_column,
  output logic [TUPLE_W-1:0]     o_display_data,
  output logic                   o_display_data_valid,
  output logic                   o_busy,
  output logic                   o_overrun,
  output logic                   o_protocol_error,
  input  logic                   i_clear_flags,
  output logic                   o_vram_req,
  output logic [VRAM_ADDR_W-1:0] o_vram_address,
  input  logic                   i_vram_grant,
  input  logic [TUPLE_W-1:0]     i_vram_rdata,
  input  logic                   i_vram_rvalid
);

  // Counters are one bit wider than the column so they can hold ROW_WORDS itself.
  localparam int              CNT_W   = COLUMN_W + 1;
  localparam logic [CNT_W-1:0] ROW_END = CNT_W'(ROW_WORDS);
  localparam logic [3:0]      OUT_MAX = 4'(MAX_OUTSTANDING);

  fetch_state_t           r_state;
  fetch_state_t           w_next_state;
  logic [VRAM_ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]       r_issue_count;
  logic [CNT_W-1:0]       r_return_count;
  logic [3:0]             r_outstanding;
  logic                   w_start_accept;
  logic                   w_issue;
  logic                   w_return;
  logic                   w_spurious;

  assign w_start_accept = i_display_start && (r_state == FETCH_IDLE);
  assign w_issue        = o_vram_req && i_vram_grant;
  assign w_return       = i_vram_rvalid && (r_outstanding != 4'd0);
  assign w_spurious     = i_vram_rvalid && (r_outstanding == 4'd0);

  assign o_busy         = (r_state != FETCH_IDLE);
  assign o_vram_address = r_base + VRAM_ADDR_W'(r_issue_count);

  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= FETCH_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request gating uses registered counts only, so req/address cannot change
  // while a request is waiting for grant.
  always_comb begin
    w_next_state = r_state;
    o_vram_req   = 1'b0;
    case (r_state)
      FETCH_IDLE: begin
        if (i_display_start) w_next_state = FETCH_REQ;
      end
      FETCH_REQ: begin
        o_vram_req = (r_issue_count < ROW_END) && (r_outstanding < OUT_MAX);
        if (r_issue_count == ROW_END) w_next_state = FETCH_DRAIN;
      end
      FETCH_DRAIN: begin
        if (r_return_count == ROW_END) w_next_state = FETCH_IDLE;
      end
      default: w_next_state = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      r_base         <= '0;
      r_issue_count  <= '0;
      r_return_count <= '0;
    end else if (w_start_accept) begin
      r_base         <= i_display_address;
      r_issue_count  <= '0;
      r_return_count <= '0;
    end else begin
      if (w_issue)  r_issue_count  <= r_issue_count + 1'b1;
      if (w_return) r_return_count <= r_return_count + 1'b1;
    end
  end

  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      r_outstanding <= 4'd0;
    end else if (w_start_accept) begin
      r_outstanding <= 4'd0;
    end else begin
      case ({w_issue, w_return})
        2'b10:   r_outstanding <= r_outstanding + 4'd1;
        2'b01:   r_outstanding <= r_outstanding - 4'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      o_display_data_valid <= 1'b0;
      o_display_column     <= '0;
      o_display_data       <= '0;
    end else begin
      o_display_data_valid <= w_return;
      if (w_return) begin
        o_display_column <= r_return_count[COLUMN_W-1:0];
        o_display_data   <= i_vram_rdata;
      end
    end
  end

  // Sticky flags: a set event in the same cycle as a clear takes priority.
  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      o_overrun        <= 1'b0;
      o_protocol_error <= 1'b0;
    end else begin
      if (i_display_start && o_busy) o_overrun <= 1'b1;
      else if (i_clear_flags)        o_overrun <= 1'b0;
      if (w_spurious)                o_protocol_error <= 1'b1;
      else if (i_clear_flags)        o_protocol_error <= 1'b0;
    end
  end

endmodule
